// File: rtl/numa_pkg.sv
// Shared types and address helpers for the NUMA memory responder.
package numa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOCAL    = 3'd1,
    ST_RMT_REQ  = 3'd2,
    ST_RMT_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } numa_state_t;

  localparam int NUMA_NODE_BITS = 2;
  localparam int NODE_LSB       = 32 - NUMA_NODE_BITS;

  // True when the node field (top nbits of addr) names node_id.
  function automatic logic is_local(input logic [31:0] addr,
                                    input logic [31:0] node_id,
                                    input int          nbits);
    logic [31:0] field;
    field = addr >> (32 - nbits);
    return (field == node_id);
  endfunction

endpackage

// File: rtl/numa_lat_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module numa_lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/numa_mem_responder.sv
// Memory-side responder for one NUMA node: local word array plus remote link relay.
// Optional build macro NUMA_STATS_EN adds completed-transaction counters.
module numa_mem_responder
  import numa_pkg::*;
#(
  parameter int NODE_ID     = 0,
  parameter int NODE_BITS   = NUMA_NODE_BITS,
  parameter int DEPTH_WORDS = 256,
  parameter int LOCAL_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        rmt_req_valid,
  input  logic        rmt_req_ready,
  output logic        rmt_we,
  output logic [31:0] rmt_addr,
  output logic [31:0] rmt_wdata,
  input  logic        rmt_resp_valid,
  input  logic [31:0] rmt_rdata
`ifdef NUMA_STATS_EN
  ,
  output logic [31:0] stat_local,
  output logic [31:0] stat_remote
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LOCAL_LAT > 1) ? $clog2(LOCAL_LAT) : 1;

  numa_state_t state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;
  logic             rmt_req_valid_q, rmt_req_valid_d;
  logic             rmt_we_q, rmt_we_d;
  logic [31:0]      rmt_addr_q, rmt_addr_d;
  logic [31:0]      rmt_wdata_q, rmt_wdata_d;

  logic             accept;
  logic             cnt_load, cnt_en, cnt_done;
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic [31:0]      mem_q [DEPTH_WORDS];

  assign accept    = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign mem_rdata = mem_q[idx_q];

  numa_lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(LOCAL_LAT - 1)),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    idx_d           = idx_q;
    wdata_d         = wdata_q;
    resp_valid_d    = resp_valid_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;
    rmt_req_valid_d = rmt_req_valid_q;
    rmt_we_d        = rmt_we_q;
    rmt_addr_d      = rmt_addr_q;
    rmt_wdata_d     = rmt_wdata_q;
    cnt_load        = 1'b0;
    cnt_en          = 1'b0;
    mem_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          idx_d   = req_addr[2 +: IDX_W];
          wdata_d = req_wdata;
          if (req_addr[1:0] != 2'b00) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0000_0000;
          end else if (is_local(req_addr, 32'(NODE_ID), NODE_BITS)) begin
            state_d  = ST_LOCAL;
            cnt_load = 1'b1;
          end else begin
            state_d         = ST_RMT_REQ;
            rmt_req_valid_d = 1'b1;
            rmt_we_d        = req_we;
            rmt_addr_d      = req_addr;
            rmt_wdata_d     = req_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCAL: begin
        // Array write and read both happen on the edge that enters RESP.
        if (cnt_done) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0000_0000 : mem_rdata;
          mem_we       = we_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RMT_REQ: begin
        if (rmt_req_ready) begin
          state_d         = ST_RMT_WAIT;
          rmt_req_valid_d = 1'b0;
        end else begin
          rmt_req_valid_d = 1'b1;
        end
      end
      ST_RMT_WAIT: begin
        if (rmt_resp_valid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0000_0000 : rmt_rdata;
        end else begin
          state_d = ST_RMT_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0000_0000;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b0;
      we_q            <= 1'b0;
      idx_q           <= '0;
      wdata_q         <= 32'h0000_0000;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'h0000_0000;
      resp_err_q      <= 1'b0;
      rmt_req_valid_q <= 1'b0;
      rmt_we_q        <= 1'b0;
      rmt_addr_q      <= 32'h0000_0000;
      rmt_wdata_q     <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      we_q            <= we_d;
      idx_q           <= idx_d;
      wdata_q         <= wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      rmt_req_valid_q <= rmt_req_valid_d;
      rmt_we_q        <= rmt_we_d;
      rmt_addr_q      <= rmt_addr_d;
      rmt_wdata_q     <= rmt_wdata_d;
    end
  end

  // Local word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

`ifdef NUMA_STATS_EN
  logic        is_rmt_q, is_rmt_d;
  logic [31:0] stat_local_q, stat_local_d;
  logic [31:0] stat_remote_q, stat_remote_d;

  // Counters advance on a completed, error-free response handshake.
  always_comb begin
    is_rmt_d      = is_rmt_q;
    stat_local_d  = stat_local_q;
    stat_remote_d = stat_remote_q;
    if (accept) begin
      is_rmt_d = !is_local(req_addr, 32'(NODE_ID), NODE_BITS);
    end else begin
      is_rmt_d = is_rmt_q;
    end
    if ((state_q == ST_RESP) && resp_ready && !resp_err_q) begin
      if (is_rmt_q) begin
        stat_remote_d = stat_remote_q + 32'd1;
      end else begin
        stat_local_d = stat_local_q + 32'd1;
      end
    end else begin
      stat_local_d = stat_local_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_rmt_q      <= 1'b0;
      stat_local_q  <= 32'h0000_0000;
      stat_remote_q <= 32'h0000_0000;
    end else begin
      is_rmt_q      <= is_rmt_d;
      stat_local_q  <= stat_local_d;
      stat_remote_q <= stat_remote_d;
    end
  end

  assign stat_local  = stat_local_q;
  assign stat_remote = stat_remote_q;
`endif

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign rmt_req_valid = rmt_req_valid_q;
  assign rmt_we        = rmt_we_q;
  assign rmt_addr      = rmt_addr_q;
  assign rmt_wdata     = rmt_wdata_q;

endmodule

// File: tb/tb_numa_mem_responder.sv
// Self-checking bench for numa_mem_responder: directed plan followed by random traffic.
module tb_numa_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        rmt_req_valid, rmt_req_ready, rmt_we;
  logic [31:0] rmt_addr, rmt_wdata;
  logic        rmt_resp_valid;
  logic [31:0] rmt_rdata;
`ifdef NUMA_STATS_EN
  logic [31:0] stat_local, stat_remote;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: word array indexed by addr[9:2], written-index list, stat counts.
  logic [31:0] model_mem [256];
  int          wr_q [$];
  int          exp_local  = 0;
  int          exp_remote = 0;

  always #5 clk = ~clk;

  numa_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .rmt_req_valid  (rmt_req_valid),
    .rmt_req_ready  (rmt_req_ready),
    .rmt_we         (rmt_we),
    .rmt_addr       (rmt_addr),
    .rmt_wdata      (rmt_wdata),
    .rmt_resp_valid (rmt_resp_valid),
    .rmt_rdata      (rmt_rdata)
`ifdef NUMA_STATS_EN
    ,
    .stat_local     (stat_local),
    .stat_remote    (stat_remote)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with a remote-ready delay and a response backpressure delay.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rrd, input int rq_delay, input int rs_delay);
    logic        mis, loc;
    logic [31:0] exp_d;
    int          lat;
    mis = (addr[1:0] != 2'b00);
    loc = (addr[31:30] == 2'b00);
    if (mis || we)  exp_d = 32'h0;
    else if (loc)   exp_d = model_mem[addr[9:2]];
    else            exp_d = rrd;

    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);

    if (!mis && !loc) begin
      chk("rmt_valid", {31'b0, rmt_req_valid}, 32'd1);
      chk("rmt_addr", rmt_addr, addr);
      chk("rmt_we", {31'b0, rmt_we}, {31'b0, we});
      chk("rmt_wdata", rmt_wdata, wdata);
      for (int i = 0; i < rq_delay; i++) begin
        step();
        chk("rmt_hold_valid", {31'b0, rmt_req_valid}, 32'd1);
        chk("rmt_hold_addr", rmt_addr, addr);
        chk("rmt_hold_we", {31'b0, rmt_we}, {31'b0, we});
      end
      rmt_req_ready = 1'b1;
      step();
      rmt_req_ready = 1'b0;
      chk("rmt_valid_drop", {31'b0, rmt_req_valid}, 32'd0);
      chk("resp_before_rmt", {31'b0, resp_valid}, 32'd0);
      rmt_resp_valid = 1'b1; rmt_rdata = rrd;
      step();
      rmt_resp_valid = 1'b0; rmt_rdata = $urandom;
    end else begin
      lat = 0;
      while (!resp_valid && lat < 20) begin
        step();
        lat++;
      end
      chk("resp_latency", 32'(lat), mis ? 32'd0 : 32'd2);
      chk("no_rmt_req", {31'b0, rmt_req_valid}, 32'd0);
    end

    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, exp_d);
    chk("resp_err", {31'b0, resp_err}, {31'b0, mis});
    for (int i = 0; i < rs_delay; i++) begin
      step();
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, exp_d);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_drop", {31'b0, resp_valid}, 32'd0);
    chk("err_clear", {31'b0, resp_err}, 32'd0);
    chk("req_ready_again", {31'b0, req_ready}, 32'd1);

    if (!mis && loc && we) begin
      model_mem[addr[9:2]] = wdata;
      wr_q.push_back(int'(addr[9:2]));
    end
    if (!mis) begin
      if (loc) exp_local++;
      else     exp_remote++;
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef NUMA_STATS_EN
    chk({tag, "_local"}, stat_local, 32'(exp_local));
    chk({tag, "_remote"}, stat_remote, 32'(exp_remote));
`else
    chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
`endif
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  idx;
    logic [1:0]  node;
    int          kind;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; rmt_req_ready = 1'b0; rmt_resp_valid = 1'b0; rmt_rdata = 32'h0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_rmt_valid", {31'b0, rmt_req_valid}, 32'd0);
    chk("rst_rmt_addr", rmt_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Directed plan.
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0);
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 0);
    xact(1'b0, 32'h4000_0020, 32'h0, 32'h1234_5678, 3, 0);
    xact(1'b0, 32'h0000_0013, 32'h0, 32'h0, 0, 0);
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 0);
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 4);
    xact(1'b0, 32'h0040_0010, 32'h0, 32'h0, 0, 0);

    // Reset while waiting on a remote store response.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0040; req_wdata = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    chk("pre_rst_rmt_we", {31'b0, rmt_we}, 32'd1);
    rmt_req_ready = 1'b1;
    step();
    rmt_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("arst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("arst_rdata", resp_rdata, 32'h0);
    chk("arst_rmt_valid", {31'b0, rmt_req_valid}, 32'd0);
    chk("arst_rmt_we", {31'b0, rmt_we}, 32'd0);
    chk("arst_rmt_addr", rmt_addr, 32'h0);
    chk("arst_rmt_wdata", rmt_wdata, 32'h0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd0);
    exp_local = 0;
    exp_remote = 0;
    step();
    reset = 1'b0;
    step();
    rmt_resp_valid = 1'b1; rmt_rdata = 32'hBAD0_BAD0;
    step();
    rmt_resp_valid = 1'b0;
    chk("late_rmt_ignored", {31'b0, resp_valid}, 32'd0);
    step();
    chk("late_rmt_still_idle", {31'b0, resp_valid}, 32'd0);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk_stats("stat_after_rst");

    // Two local, one remote, one misaligned.
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 0);
    xact(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 32'h0, 0, 1);
    xact(1'b0, 32'hC000_0008, 32'h0, 32'h0F0F_0F0F, 1, 0);
    xact(1'b1, 32'h0000_0102, 32'h1111_1111, 32'h0, 0, 0);
    chk_stats("stat_mix");

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          idx = 8'($urandom);
          a = {2'b00, 20'($urandom), idx, 2'b00};
          xact(1'b1, a, $urandom, $urandom, 0, $urandom_range(0, 3));
        end
        1: begin
          idx = 8'(wr_q[$urandom_range(0, wr_q.size() - 1)]);
          a = {2'b00, 20'($urandom), idx, 2'b00};
          xact(1'b0, a, $urandom, $urandom, 0, $urandom_range(0, 3));
        end
        2, 3: begin
          node = 2'($urandom_range(1, 3));
          a = {node, 28'($urandom), 2'b00};
          xact(kind == 2, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        default: begin
          a = $urandom;
          a[1:0] = 2'($urandom_range(1, 3));
          xact(1'($urandom), a, $urandom, $urandom, 0, $urandom_range(0, 2));
        end
      endcase
    end
    chk_stats("stat_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
